// File: rtl/board_state_ctrl.sv
// board_state_ctrl: ROWS x COLS board store with pick/place moves gated by a
// legal-move mask, capture/illegal reporting and a registered hint query.
// Optional undo history is built when BOARD_UNDO_EN is defined.
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   sel_pos             target square {row,col} for pick/place
//   pick_req/place_req  single-cycle pick and place requests
//   possible_moves      legal-destination mask, bit row*COLS+col
//   query_pos/code      square read-back, 1-cycle latency, hint overlay
//   board_flat          whole board, square i at [i*CODE_W +: CODE_W]
//   holding/held_*      lifted piece state
//   move_done/illegal   1-cycle result pulses
//   captured_code       code overwritten by the last committed move
//   undo_req/hist_count undo request and stored-move count
module board_state_ctrl #(
    parameter int unsigned       ROWS       = 8,
    parameter int unsigned       COLS       = 8,
    parameter int unsigned       CODE_W     = 4,
    parameter logic [CODE_W-1:0] HINT_CODE  = 4'hD,
    parameter bit                INIT_STD   = 1'b1,
    parameter int unsigned       HIST_DEPTH = 16,
    localparam int unsigned      POS_W      = $clog2(ROWS) + $clog2(COLS),
    localparam int unsigned      HC_W       = $clog2(HIST_DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [POS_W-1:0]            sel_pos,
    input  logic                        pick_req,
    input  logic                        place_req,
    input  logic [ROWS*COLS-1:0]        possible_moves,
    input  logic [POS_W-1:0]            query_pos,
    output logic [CODE_W-1:0]           query_code,
    output logic [ROWS*COLS*CODE_W-1:0] board_flat,
    output logic                        holding,
    output logic [CODE_W-1:0]           held_code,
    output logic [POS_W-1:0]            held_pos,
    output logic                        move_done,
    output logic [CODE_W-1:0]           captured_code,
    output logic                        illegal,
    input  logic                        undo_req,
    output logic [HC_W-1:0]             hist_count
);

    localparam int unsigned RB = $clog2(ROWS);
    localparam int unsigned CB = $clog2(COLS);
    localparam int unsigned SQ = ROWS * COLS;

    typedef enum logic {IDLE, HELD} state_e;
    typedef logic [CODE_W-1:0] code_t;

    // Reset layout; back ranks are stored MSB-first (column 0 in [31:28]).
    function automatic code_t init_code(int unsigned idx);
        logic [31:0] rank0;
        logic [31:0] rank7;
        logic [3:0]  v;
        int unsigned r;
        int unsigned c;
        rank0 = 32'hA98B_C89A;
        rank7 = 32'h4325_6234;
        r = idx / COLS;
        c = idx % COLS;
        v = 4'h0;
        if (INIT_STD && ROWS == 8 && COLS == 8) begin
            if (r == 0)      v = rank0[31-4*c -: 4];
            else if (r == 1) v = 4'h7;
            else if (r == 6) v = 4'h1;
            else if (r == 7) v = rank7[31-4*c -: 4];
        end
        return code_t'(v);
    endfunction

    state_e           state_q, state_d;
    code_t            board_q [SQ];
    code_t            board_d [SQ];
    code_t            held_code_q, held_code_d;
    logic [POS_W-1:0] held_pos_q, held_pos_d;
    logic             move_done_q, move_done_d;
    logic             illegal_q, illegal_d;
    code_t            cap_q, cap_d;
    code_t            query_q, query_d;
    logic             push;
    logic             pop;

    // Always true for power-of-two sizes; kept as a guard on the parameters.
    logic [RB-1:0] sel_row;
    logic [CB-1:0] sel_col;
    logic          sel_ok;
    assign sel_row = sel_pos[POS_W-1 -: RB];
    assign sel_col = sel_pos[CB-1:0];
    assign sel_ok  = (int'(sel_row) < ROWS) && (int'(sel_col) < COLS);

`ifdef BOARD_UNDO_EN
    localparam int unsigned     HP_W    = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
    localparam logic [HP_W-1:0] HP_LAST = HP_W'(HIST_DEPTH - 1);
    localparam logic [HC_W-1:0] HC_FULL = HC_W'(HIST_DEPTH);

    typedef struct packed {
        logic [POS_W-1:0] from;
        logic [POS_W-1:0] to;
        code_t            piece;
        code_t            cap;
    } hist_t;

    hist_t           hist_mem [HIST_DEPTH];
    hist_t           push_e;
    hist_t           pop_e;
    logic [HP_W-1:0] top_q, top_d;
    logic [HP_W-1:0] top_m1;
    logic [HC_W-1:0] cnt_q, cnt_d;

    // top_q is the next write slot; the newest entry sits just below it.
    assign top_m1 = (top_q == '0) ? HP_LAST : top_q - HP_W'(1);
    assign pop_e  = hist_mem[top_m1];
    assign push_e = {held_pos_q, sel_pos, held_code_q, board_q[sel_pos]};

    always_comb begin
        top_d = top_q;
        cnt_d = cnt_q;
        if (push) begin
            top_d = (top_q == HP_LAST) ? '0 : top_q + HP_W'(1);
            if (cnt_q != HC_FULL) cnt_d = cnt_q + HC_W'(1);
        end else if (pop) begin
            top_d = top_m1;
            cnt_d = cnt_q - HC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) hist_mem[top_q] <= push_e;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_q <= '0;
            cnt_q <= '0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
        end
    end

    assign hist_count = cnt_q;
`else
    logic unused_undo;
    assign unused_undo = undo_req;
    assign hist_count  = '0;
`endif

    always_comb begin
        state_d     = state_q;
        board_d     = board_q;
        held_code_d = held_code_q;
        held_pos_d  = held_pos_q;
        move_done_d = 1'b0;
        illegal_d   = 1'b0;
        cap_d       = cap_q;
        push        = 1'b0;
        pop         = 1'b0;

        query_d = board_q[query_pos];
        if (query_d == '0 && possible_moves[query_pos]) query_d = HINT_CODE;

        unique case (state_q)
            IDLE: begin
                if (pick_req) begin
                    if (sel_ok && board_q[sel_pos] != '0) begin
                        held_code_d      = board_q[sel_pos];
                        held_pos_d       = sel_pos;
                        board_d[sel_pos] = '0;
                        state_d          = HELD;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
`ifdef BOARD_UNDO_EN
                else if (undo_req && !place_req) begin
                    if (cnt_q != '0) begin
                        board_d[pop_e.to]   = pop_e.cap;
                        board_d[pop_e.from] = pop_e.piece;
                        pop                 = 1'b1;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
`endif
            end
            HELD: begin
                if (place_req) begin
                    if (sel_pos == held_pos_q) begin
                        board_d[sel_pos] = held_code_q;
                        held_code_d      = '0;
                        held_pos_d       = '0;
                        state_d          = IDLE;
                    end else if (sel_ok && possible_moves[sel_pos]) begin
                        cap_d            = board_q[sel_pos];
                        board_d[sel_pos] = held_code_q;
                        held_code_d      = '0;
                        held_pos_d       = '0;
                        move_done_d      = 1'b1;
                        push             = 1'b1;
                        state_d          = IDLE;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
`ifdef BOARD_UNDO_EN
                else if (undo_req && !pick_req) begin
                    illegal_d = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            held_code_q <= '0;
            held_pos_q  <= '0;
            move_done_q <= 1'b0;
            illegal_q   <= 1'b0;
            cap_q       <= '0;
            query_q     <= '0;
            for (int unsigned i = 0; i < SQ; i++) begin
                board_q[i] <= init_code(i);
            end
        end else begin
            state_q     <= state_d;
            held_code_q <= held_code_d;
            held_pos_q  <= held_pos_d;
            move_done_q <= move_done_d;
            illegal_q   <= illegal_d;
            cap_q       <= cap_d;
            query_q     <= query_d;
            board_q     <= board_d;
        end
    end

    for (genvar g = 0; g < SQ; g++) begin : g_flat
        assign board_flat[g*CODE_W +: CODE_W] = board_q[g];
    end

    assign holding       = (state_q == HELD);
    assign held_code     = held_code_q;
    assign held_pos      = held_pos_q;
    assign move_done     = move_done_q;
    assign illegal       = illegal_q;
    assign captured_code = cap_q;
    assign query_code    = query_q;

endmodule

// File: tb/tb_board_state_ctrl.sv
// tb_board_state_ctrl: directed checks of board_state_ctrl at the
// default 8x8 configuration, with undo checks when BOARD_UNDO_EN is set.
module tb_board_state_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [5:0]   sel_pos = '0;
    logic         pick_req = 1'b0;
    logic         place_req = 1'b0;
    logic [63:0]  possible_moves = '0;
    logic [5:0]   query_pos = '0;
    logic [3:0]   query_code;
    logic [255:0] board_flat;
    logic         holding;
    logic [3:0]   held_code;
    logic [5:0]   held_pos;
    logic         move_done;
    logic [3:0]   captured_code;
    logic         illegal;
    logic         undo_req = 1'b0;
    logic [4:0]   hist_count;

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_b [64];
    logic [4:0] exp_hist;

    board_state_ctrl dut (
        .clk(clk), .rst(rst), .sel_pos(sel_pos),
        .pick_req(pick_req), .place_req(place_req),
        .possible_moves(possible_moves), .query_pos(query_pos),
        .query_code(query_code), .board_flat(board_flat),
        .holding(holding), .held_code(held_code), .held_pos(held_pos),
        .move_done(move_done), .captured_code(captured_code),
        .illegal(illegal), .undo_req(undo_req), .hist_count(hist_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic exp_init();
        logic [3:0] r0 [8] = '{4'hA, 4'h9, 4'h8, 4'hB, 4'hC, 4'h8, 4'h9, 4'hA};
        logic [3:0] r7 [8] = '{4'h4, 4'h3, 4'h2, 4'h5, 4'h6, 4'h2, 4'h3, 4'h4};
        for (int i = 0; i < 64; i++) exp_b[i] = 4'h0;
        for (int c = 0; c < 8; c++) begin
            exp_b[c]      = r0[c];
            exp_b[8 + c]  = 4'h7;
            exp_b[48 + c] = 4'h1;
            exp_b[56 + c] = r7[c];
        end
        exp_hist = '0;
    endtask

    function automatic logic [255:0] exp_flat();
        logic [255:0] v;
        for (int i = 0; i < 64; i++) v[i*4 +: 4] = exp_b[i];
        return v;
    endfunction

    function automatic logic [3:0] sq(input logic [5:0] p);
        return board_flat[int'(p)*4 +: 4];
    endfunction

    // Called at a falling edge; returns one falling edge later.
    task automatic req(input logic pk, input logic pl, input logic ud,
                       input logic [5:0] pos);
        sel_pos = pos; pick_req = pk; place_req = pl; undo_req = ud;
        @(negedge clk);
        pick_req = 1'b0; place_req = 1'b0; undo_req = 1'b0;
    endtask

    task automatic test_reset();
        exp_init();
        checks++; if (holding !== 1'b0) begin errors++; $display("FAIL rst_holding got %0h exp 0", holding); end
        checks++; if (held_code !== 4'h0) begin errors++; $display("FAIL rst_held_code got %0h exp 0", held_code); end
        checks++; if (move_done !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL rst_pulses got %0b%0b exp 00", move_done, illegal); end
        checks++; if (captured_code !== 4'h0) begin errors++; $display("FAIL rst_captured got %0h exp 0", captured_code); end
        checks++; if (hist_count !== 5'd0) begin errors++; $display("FAIL rst_hist got %0d exp 0", hist_count); end
        checks++; if (query_code !== 4'h0) begin errors++; $display("FAIL rst_query got %0h exp 0", query_code); end
        checks++; if (board_flat !== exp_flat()) begin errors++; $display("FAIL rst_board got %h exp %h", board_flat, exp_flat()); end
        query_pos = 6'o04;
        @(negedge clk);
        checks++; if (query_code !== 4'hC) begin errors++; $display("FAIL q_o04 got %0h exp C", query_code); end
        query_pos = 6'o73;
        @(negedge clk);
        checks++; if (query_code !== 4'h5) begin errors++; $display("FAIL q_o73 got %0h exp 5", query_code); end
    endtask

    task automatic test_hint();
        possible_moves = '0;
        possible_moves[6'o33] = 1'b1;
        possible_moves[6'o04] = 1'b1;
        query_pos = 6'o33;
        @(negedge clk);
        checks++; if (query_code !== 4'hD) begin errors++; $display("FAIL hint_empty got %0h exp D", query_code); end
        query_pos = 6'o04;
        @(negedge clk);
        checks++; if (query_code !== 4'hC) begin errors++; $display("FAIL hint_occupied got %0h exp C", query_code); end
        query_pos = 6'o33;
        possible_moves = '0;
        @(negedge clk);
        checks++; if (query_code !== 4'h0) begin errors++; $display("FAIL hint_off got %0h exp 0", query_code); end
    endtask

    task automatic test_move();
        req(1'b1, 1'b0, 1'b0, 6'o61);
        exp_b[6'o61] = 4'h0;
        checks++; if (holding !== 1'b1) begin errors++; $display("FAIL mv_holding got %0h exp 1", holding); end
        checks++; if (held_code !== 4'h1 || held_pos !== 6'o61) begin errors++; $display("FAIL mv_held got %0h@%0o exp 1@61", held_code, held_pos); end
        checks++; if (sq(6'o61) !== 4'h0) begin errors++; $display("FAIL mv_lifted got %0h exp 0", sq(6'o61)); end
        possible_moves[6'o51] = 1'b1;
        req(1'b0, 1'b1, 1'b0, 6'o51);
        exp_b[6'o51] = 4'h1;
`ifdef BOARD_UNDO_EN
        exp_hist = 5'd1;
`endif
        checks++; if (move_done !== 1'b1) begin errors++; $display("FAIL mv_done got %0h exp 1", move_done); end
        checks++; if (board_flat !== exp_flat()) begin errors++; $display("FAIL mv_board got %h exp %h", board_flat, exp_flat()); end
        checks++; if (captured_code !== 4'h0) begin errors++; $display("FAIL mv_captured got %0h exp 0", captured_code); end
        checks++; if (holding !== 1'b0 || held_code !== 4'h0) begin errors++; $display("FAIL mv_release got %0h/%0h exp 0/0", holding, held_code); end
        checks++; if (hist_count !== exp_hist) begin errors++; $display("FAIL mv_hist got %0d exp %0d", hist_count, exp_hist); end
        @(negedge clk);
        checks++; if (move_done !== 1'b0) begin errors++; $display("FAIL mv_pulse_width got %0h exp 0", move_done); end
        possible_moves = '0;
    endtask

    task automatic test_illegal_place();
        req(1'b1, 1'b0, 1'b0, 6'o62);
        req(1'b0, 1'b1, 1'b0, 6'o32);
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ip_illegal got %0h exp 1", illegal); end
        checks++; if (holding !== 1'b1 || held_code !== 4'h1) begin errors++; $display("FAIL ip_still_held got %0h/%0h exp 1/1", holding, held_code); end
        checks++; if (sq(6'o32) !== 4'h0) begin errors++; $display("FAIL ip_dest got %0h exp 0", sq(6'o32)); end
        @(negedge clk);
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL ip_pulse_width got %0h exp 0", illegal); end
        req(1'b0, 1'b1, 1'b0, 6'o62);
        checks++; if (holding !== 1'b0 || move_done !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL cancel_flags got %0b%0b%0b exp 000", holding, move_done, illegal); end
        checks++; if (board_flat !== exp_flat()) begin errors++; $display("FAIL cancel_board got %h exp %h", board_flat, exp_flat()); end
        checks++; if (hist_count !== exp_hist) begin errors++; $display("FAIL cancel_hist got %0d exp %0d", hist_count, exp_hist); end
    endtask

    task automatic test_empty_pick();
        req(1'b1, 1'b0, 1'b0, 6'o33);
        checks++; if (illegal !== 1'b1 || holding !== 1'b0) begin errors++; $display("FAIL ep_flags got %0b%0b exp 10", illegal, holding); end
        checks++; if (board_flat !== exp_flat()) begin errors++; $display("FAIL ep_board got %h exp %h", board_flat, exp_flat()); end
    endtask

    task automatic test_ignored();
        possible_moves[6'o44] = 1'b1;
        req(1'b0, 1'b1, 1'b0, 6'o44);
        checks++; if (illegal !== 1'b0 || move_done !== 1'b0) begin errors++; $display("FAIL ig_place_idle got %0b%0b exp 00", illegal, move_done); end
        checks++; if (board_flat !== exp_flat()) begin errors++; $display("FAIL ig_board got %h exp %h", board_flat, exp_flat()); end
        req(1'b1, 1'b0, 1'b0, 6'o63);
        req(1'b1, 1'b0, 1'b0, 6'o64);
        checks++; if (illegal !== 1'b0 || held_pos !== 6'o63) begin errors++; $display("FAIL ig_pick_held got %0b@%0o exp 0@63", illegal, held_pos); end
        checks++; if (sq(6'o64) !== 4'h1) begin errors++; $display("FAIL ig_other_sq got %0h exp 1", sq(6'o64)); end
        req(1'b0, 1'b1, 1'b0, 6'o63);
        possible_moves = '0;
    endtask

    task automatic test_back_to_back();
        req(1'b1, 1'b1, 1'b1, 6'o60);
        checks++; if (holding !== 1'b1 || held_pos !== 6'o60) begin errors++; $display("FAIL bb_pick got %0b@%0o exp 1@60", holding, held_pos); end
        checks++; if (illegal !== 1'b0 || hist_count !== exp_hist) begin errors++; $display("FAIL bb_undo_ignored got %0b/%0d exp 0/%0d", illegal, hist_count, exp_hist); end
        req(1'b1, 1'b1, 1'b0, 6'o60);
        checks++; if (holding !== 1'b0 || move_done !== 1'b0) begin errors++; $display("FAIL bb_cancel got %0b%0b exp 00", holding, move_done); end
        checks++; if (board_flat !== exp_flat()) begin errors++; $display("FAIL bb_board got %h exp %h", board_flat, exp_flat()); end
    endtask

    task automatic test_capture();
        possible_moves = '0;
        possible_moves[6'o12] = 1'b1;
        req(1'b1, 1'b0, 1'b0, 6'o51);
        req(1'b0, 1'b1, 1'b0, 6'o12);
        exp_b[6'o51] = 4'h0;
        exp_b[6'o12] = 4'h1;
`ifdef BOARD_UNDO_EN
        exp_hist = 5'd2;
`endif
        checks++; if (move_done !== 1'b1 || captured_code !== 4'h7) begin errors++; $display("FAIL cap_result got %0b/%0h exp 1/7", move_done, captured_code); end
        checks++; if (board_flat !== exp_flat()) begin errors++; $display("FAIL cap_board got %h exp %h", board_flat, exp_flat()); end
        checks++; if (hist_count !== exp_hist) begin errors++; $display("FAIL cap_hist got %0d exp %0d", hist_count, exp_hist); end
`ifdef BOARD_UNDO_EN
        req(1'b0, 1'b0, 1'b1, 6'o00);
        exp_b[6'o12] = 4'h7;
        exp_b[6'o51] = 4'h1;
        checks++; if (board_flat !== exp_flat()) begin errors++; $display("FAIL undo1_board got %h exp %h", board_flat, exp_flat()); end
        checks++; if (hist_count !== 5'd1 || illegal !== 1'b0) begin errors++; $display("FAIL undo1_hist got %0d/%0b exp 1/0", hist_count, illegal); end
        checks++; if (captured_code !== 4'h7 || move_done !== 1'b0) begin errors++; $display("FAIL undo1_cap got %0h/%0b exp 7/0", captured_code, move_done); end
        req(1'b0, 1'b0, 1'b1, 6'o00);
        exp_b[6'o51] = 4'h0;
        exp_b[6'o61] = 4'h1;
        checks++; if (board_flat !== exp_flat()) begin errors++; $display("FAIL undo2_board got %h exp %h", board_flat, exp_flat()); end
        checks++; if (hist_count !== 5'd0) begin errors++; $display("FAIL undo2_hist got %0d exp 0", hist_count); end
        req(1'b0, 1'b0, 1'b1, 6'o00);
        checks++; if (illegal !== 1'b1 || hist_count !== 5'd0) begin errors++; $display("FAIL undo_empty got %0b/%0d exp 1/0", illegal, hist_count); end
        req(1'b1, 1'b0, 1'b0, 6'o61);
        req(1'b0, 1'b0, 1'b1, 6'o00);
        checks++; if (illegal !== 1'b1 || holding !== 1'b1) begin errors++; $display("FAIL undo_held got %0b/%0b exp 1/1", illegal, holding); end
        req(1'b0, 1'b1, 1'b0, 6'o61);
        exp_hist = 5'd0;
`else
        req(1'b0, 1'b0, 1'b1, 6'o00);
        checks++; if (illegal !== 1'b0 || hist_count !== 5'd0) begin errors++; $display("FAIL undo_off got %0b/%0d exp 0/0", illegal, hist_count); end
        checks++; if (board_flat !== exp_flat()) begin errors++; $display("FAIL undo_off_board got %h exp %h", board_flat, exp_flat()); end
`endif
        possible_moves = '0;
    endtask

    task automatic test_reset_mid();
        req(1'b1, 1'b0, 1'b0, 6'o00);
        checks++; if (holding !== 1'b1 || held_code !== 4'hA) begin errors++; $display("FAIL rm_pick got %0b/%0h exp 1/A", holding, held_code); end
        #2 rst = 1'b1;
        #1;
        exp_init();
        checks++; if (holding !== 1'b0 || held_code !== 4'h0) begin errors++; $display("FAIL rm_holding got %0b/%0h exp 0/0", holding, held_code); end
        checks++; if (board_flat !== exp_flat()) begin errors++; $display("FAIL rm_board got %h exp %h", board_flat, exp_flat()); end
        checks++; if (hist_count !== 5'd0 || captured_code !== 4'h0) begin errors++; $display("FAIL rm_hist got %0d/%0h exp 0/0", hist_count, captured_code); end
        @(negedge clk);
        rst = 1'b0;
        req(1'b1, 1'b0, 1'b0, 6'o00);
        checks++; if (held_code !== 4'hA || held_pos !== 6'o00) begin errors++; $display("FAIL rm_repick got %0h@%0o exp A@0", held_code, held_pos); end
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_hint();
        test_move();
        test_illegal_place();
        test_empty_pick();
        test_ignored();
        test_back_to_back();
        test_capture();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
